// File: rtl/ibex_multdiv_issue_ctrl.sv
// ibex_multdiv_issue_ctrl
//
// Issue/retire controller placed in front of the slow multiplier/divider.
// It accepts one M-extension request, holds its operands stable for the unit,
// and runs the unit until it reports a result. The result is registered and
// then offered to writeback. A one-entry result cache returns a repeated
// identical request without re-issuing it. The cache is bypassed whenever
// data-independent timing is requested.
//
// Ports
//   clk_int, rst_ni            clock, asynchronous active-low reset
//   req_*                      request handshake and payload (op, signed mode, a, b, rd)
//   flush_i                    kills the pending/in-flight request
//   data_ind_timing_i          forces cache misses
//   mult_en_o/div_en_o         dynamic enables to the unit
//   mult_sel_o/div_sel_o       static selects to the unit
//   operator_o, signed_mode_o,
//   op_a_o, op_b_o             latched request fields driven to the unit
//   md_valid_i, md_result_i    unit result
//   multdiv_ready_id_o         acknowledge to the unit
//   wb_*                       result handshake to writeback
//   busy_o                     controller not idle
//   cycles_o                   BUSY cycles of the last completed, non-flushed, non-hit op (saturating)

module ibex_multdiv_issue_ctrl #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk_int,
  input  logic            rst_ni,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [1:0]      req_signed_mode_i,
  input  logic [31:0]     req_op_a_i,
  input  logic [31:0]     req_op_b_i,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  input  logic            data_ind_timing_i,

  output logic            mult_en_o,
  output logic            div_en_o,
  output logic            mult_sel_o,
  output logic            div_sel_o,
  output logic [1:0]      operator_o,
  output logic [1:0]      signed_mode_o,
  output logic [31:0]     op_a_o,
  output logic [31:0]     op_b_o,

  input  logic            md_valid_i,
  input  logic [31:0]     md_result_i,
  output logic            multdiv_ready_id_o,

  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [31:0]     wb_result_o,

  output logic            busy_o,
  output logic [CntW-1:0] cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Cache key is {operator, signed mode, a, b}.
  localparam int unsigned KeyW = 2 + 2 + 32 + 32;

  state_e              state_q, state_d;

  logic [1:0]          operator_q;
  logic [1:0]          signed_mode_q;
  logic [31:0]         op_a_q;
  logic [31:0]         op_b_q;
  logic [4:0]          rd_q;
  logic [31:0]         wb_result_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     cycles_q;

  logic                cache_valid_q;
  logic [KeyW-1:0]     cache_key_q;
  logic [31:0]         cache_result_q;

  logic [KeyW-1:0]     req_key;
  logic                accept;
  logic                hit;
  logic                complete;
  logic                is_div;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CntW'(1);
  endfunction

  assign req_ready_o = (state_q == IDLE) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign req_key     = {req_op_i, req_signed_mode_i, req_op_a_i, req_op_b_i};
  assign hit         = cache_valid_q & ~data_ind_timing_i & (cache_key_q == req_key);
  // A result arriving together with a flush is dropped, so it must not
  // count as a completion.
  assign complete    = (state_q == BUSY) & md_valid_i & ~flush_i;
  // DIV=2 and REM=3 are the only operators with bit 1 set.
  assign is_div      = operator_q[1];

  // State register
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = hit ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (md_valid_i && !flush_i) begin
          state_d = RESP;
        end else if (flush_i && !md_valid_i) begin
          state_d = DRAIN;
        end else if (flush_i && md_valid_i) begin
          state_d = IDLE;
        end
      end
      // The unit cannot be aborted, so let it finish and discard its result.
      DRAIN: begin
        if (md_valid_i) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush_i || wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mult_en_o          = 1'b0;
    div_en_o           = 1'b0;
    mult_sel_o         = 1'b0;
    div_sel_o          = 1'b0;
    multdiv_ready_id_o = 1'b0;
    wb_valid_o         = 1'b0;
    unique case (state_q)
      BUSY, DRAIN: begin
        mult_en_o          = ~is_div;
        mult_sel_o         = ~is_div;
        div_en_o           = is_div;
        div_sel_o          = is_div;
        multdiv_ready_id_o = 1'b1;
      end
      RESP: begin
        wb_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Latched request, result register, latency counter and result cache
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      operator_q     <= '0;
      signed_mode_q  <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      rd_q           <= '0;
      wb_result_q    <= '0;
      cnt_q          <= '0;
      cycles_q       <= '0;
      cache_valid_q  <= 1'b0;
      cache_key_q    <= '0;
      cache_result_q <= '0;
    end else begin
      if (accept) begin
        operator_q    <= req_op_i;
        signed_mode_q <= req_signed_mode_i;
        op_a_q        <= req_op_a_i;
        op_b_q        <= req_op_b_i;
        rd_q          <= req_rd_i;
        if (hit) begin
          wb_result_q <= cache_result_q;
        end else begin
          cnt_q <= '0;
        end
      end
      if (state_q == BUSY) begin
        cnt_q <= sat_inc(cnt_q);
      end
      if (complete) begin
        wb_result_q    <= md_result_i;
        cache_valid_q  <= 1'b1;
        cache_key_q    <= {operator_q, signed_mode_q, op_a_q, op_b_q};
        cache_result_q <= md_result_i;
        // Count the completing cycle itself as well.
        cycles_q       <= sat_inc(cnt_q);
      end
    end
  end

  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign wb_rd_o       = rd_q;
  assign wb_result_o   = wb_result_q;
  assign busy_o        = (state_q != IDLE);
  assign cycles_o      = cycles_q;

endmodule

// File: doc/ibex_multdiv_issue_ctrl.md
Name: ibex_multdiv_issue_ctrl

Overview:
- Issue/retire controller directly upstream of the slow multiplier/divider.
- Accepts one M-extension request via valid/ready, holds operands stable, and drives the unit's enable/select/operand inputs.
- Acknowledges the unit's valid with a ready, captures the result into an output register, and presents it to writeback via valid/ready.
- A one-entry result cache returns a repeated identical request without re-issuing. Cache is disabled in data-independent-timing mode.

Parameters:
CntW, 6, width of the saturating latency counter cycles_o

Ports:
clk_int  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  2  md_op_e: MULL=0, MULH=1, DIV=2, REM=3
req_signed_mode_i  in  2  [0]=op_a signed, [1]=op_b signed
req_op_a_i  in  32  operand a
req_op_b_i  in  32  operand b
req_rd_i  in  5  destination register tag
flush_i  in  1  kill in-flight/pending request
data_ind_timing_i  in  1  disables cache hits
mult_en_o / div_en_o  out  1 each  dynamic enables to unit
mult_sel_o / div_sel_o  out  1 each  static selects to unit
operator_o  out  2  latched operator
signed_mode_o  out  2  latched signed mode
op_a_o / op_b_o  out  32 each  latched operands
md_valid_i  in  1  unit result valid
md_result_i  in  32  unit result
multdiv_ready_id_o  out  1  ack to unit
wb_valid_o  out  1  result valid to writeback
wb_ready_i  in  1  writeback accepts
wb_rd_o  out  5  result tag
wb_result_o  out  32  result
busy_o  out  1  state != IDLE
cycles_o  out  CntW  BUSY cycles of last completed (non-flushed, non-hit) op, saturating

Behaviour:
- Reset values: state IDLE. All enables/selects, wb_valid_o, multdiv_ready_id_o and busy_o = 0. Latched fields, wb_result_o, wb_rd_o and cycles_o = 0. Cache invalid.
- States: IDLE, BUSY, DRAIN, RESP.
- req_ready_o = (state==IDLE) & ~flush_i. A request arriving with flush_i high is not accepted.
- IDLE, on accept: latch op, signed mode, a, b, rd.
  - Hit = cache_valid & ~data_ind_timing_i & exact match of {op, signed_mode, a, b}.
  - On hit: wb_result_o = cached result, next state RESP. wb_valid_o is high the cycle after accept.
  - On miss: next state BUSY, latency counter cleared to 0.
- BUSY:
  - mult_sel_o = mult_en_o = (op is MULL/MULH). div_sel_o = div_en_o = (op is DIV/REM).
  - multdiv_ready_id_o = 1.
  - Counter increments each BUSY cycle, saturating at 2^CntW-1.
  - On md_valid_i & ~flush_i: wb_result_o <= md_result_i; cache <= {latched key, md_result_i}, valid=1; cycles_o <= counter + 1 (saturating); next state RESP.
  - On flush_i & ~md_valid_i: next state DRAIN.
  - On flush_i & md_valid_i: discard the result (no cache or cycles_o update) and go to IDLE.
- DRAIN:
  - Same enable/select/ready outputs as BUSY; the unit cannot be aborted mid-operation, so it is run to completion.
  - On md_valid_i: discard the result and go to IDLE. flush_i is ignored here.
- RESP:
  - Enables and selects = 0; wb_valid_o = 1.
  - wb_result_o and wb_rd_o are stable until wb_valid_o & wb_ready_i, then IDLE.
  - flush_i: go to IDLE without handshake; cache is retained.
- Enable outputs are 0 in IDLE and RESP, so the unit never sees a new op until the prior result is retired.
- op_a_o, op_b_o, operator_o and signed_mode_o hold the latched values in every state. They change only on accept.
- data_ind_timing_i high forces a miss; the cache is still written on completion.
- The cache is never invalidated except by reset. Operands are fully compared, so no stale-hit risk exists.

Test Plan:
- Unsigned MULL, a=7, b=6, with the slow unit attached, wb_ready_i=1 → one wb_valid_o pulse with wb_result_o=42, wb_rd_o=req_rd_i. busy_o is high from the cycle after accept until retire.
- Signed DIV, a=0xFFFFFFF9 (-7), b=2, signed_mode=2'b11 → wb_result_o=0xFFFFFFFD. A following REM with the same operands is a cache miss and returns 0xFFFFFFFF.
- Repeat the DIV with identical operands and data_ind_timing_i=0 → wb_valid_o the cycle after accept, result 0xFFFFFFFD, no enables asserted, cycles_o unchanged. With data_ind_timing_i=1 the repeat goes through BUSY.
- flush_i asserted 3 cycles into a DIV → state DRAIN, enables stay high until md_valid_i, then IDLE with no wb_valid_o. The next MULL 3×5 returns 15.
- wb_ready_i held 0 for 5 cycles in RESP → wb_valid_o, wb_result_o and wb_rd_o stable, req_ready_o=0. Release → IDLE next cycle. Also: req_valid_i with flush_i high in IDLE → req_ready_o=0 and nothing latched.
- Assert rst_ni low while in BUSY → all outputs return to reset values asynchronously and the cache is invalid. A DIV by 0 (a=5, b=0, unsigned) then returns 0xFFFFFFFF.
